// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment feeder: active-low segment
// patterns (bit0..6 = a..g, bit7 = dp), bit positions and the handshake states.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } feed_state_e;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_HEX_0;
            4'h1:    return SEG_HEX_1;
            4'h2:    return SEG_HEX_2;
            4'h3:    return SEG_HEX_3;
            4'h4:    return SEG_HEX_4;
            4'h5:    return SEG_HEX_5;
            4'h6:    return SEG_HEX_6;
            4'h7:    return SEG_HEX_7;
            4'h8:    return SEG_HEX_8;
            4'h9:    return SEG_HEX_9;
            4'hA:    return SEG_HEX_A;
            4'hB:    return SEG_HEX_B;
            4'hC:    return SEG_HEX_C;
            4'hD:    return SEG_HEX_D;
            4'hE:    return SEG_HEX_E;
            4'hF:    return SEG_HEX_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble decoder: hex digit, decimal point and blank to an
// active-low segment pattern. A blanked digit still shows its decimal point.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] base_s;

    // Glyph selection before the decimal point is merged in
    always_comb begin
        base_s = SEG_BLANK;
        if (blank) begin
            base_s = SEG_BLANK;
        end else begin
            base_s = hex_to_seg(nibble);
        end
    end

    assign seg = {base_s[SEG_DP_BIT] & ~dp, base_s[SEG_G_BIT:SEG_A_BIT]};

endmodule

// File: rtl/seg_feed.sv
// Feeder for the two-digit seven-segment switcher: scan divider, load handshake
// and frame-aligned commit of the displayed value so a digit pair never tears.
module seg_feed
    import seg_pkg::*;
#(
    parameter int DIV_COUNT = 50000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic [1:0] dp,
    input  logic       blank_lz,
    input  logic       load,
    output logic       ready,
    output logic       clkDiv,
    output logic [7:0] led1,
    output logic [7:0] led2,
    output logic       frame
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             clk_div_r;
    feed_state_e      state_r;
    logic             ready_r;
    logic [7:0]       pend_value_r;
    logic [1:0]       pend_dp_r;
    logic             pend_blank_r;
    logic [7:0]       shadow_value_r;
    logic [1:0]       shadow_dp_r;
    logic             shadow_blank_r;
    logic [7:0]       led1_r;
    logic [7:0]       led2_r;
    logic             frame_r;

    logic             tc_s;
    logic             boundary_s;
    logic             commit_s;
    logic [7:0]       disp_value_s;
    logic [1:0]       disp_dp_s;
    logic             disp_blank_s;
    logic             blank1_s;
    logic [7:0]       seg1_s;
    logic [7:0]       seg2_s;

    assign tc_s       = (cnt_r == CNT_LAST);
    assign boundary_s = tc_s & clk_div_r;
    assign commit_s   = boundary_s & (state_r == ST_PEND);

    // The output registers load at the boundary edge, so decode what the shadow is about to hold
    always_comb begin
        disp_value_s = shadow_value_r;
        disp_dp_s    = shadow_dp_r;
        disp_blank_s = shadow_blank_r;
        if (commit_s) begin
            disp_value_s = pend_value_r;
            disp_dp_s    = pend_dp_r;
            disp_blank_s = pend_blank_r;
        end else begin
            disp_value_s = shadow_value_r;
            disp_dp_s    = shadow_dp_r;
            disp_blank_s = shadow_blank_r;
        end
    end

    assign blank1_s = disp_blank_s & (disp_value_s[7:4] == 4'h0);

    hex7seg u_digit1 (
        .nibble (disp_value_s[7:4]),
        .dp     (disp_dp_s[1]),
        .blank  (blank1_s),
        .seg    (seg1_s)
    );

    hex7seg u_digit2 (
        .nibble (disp_value_s[3:0]),
        .dp     (disp_dp_s[0]),
        .blank  (1'b0),
        .seg    (seg2_s)
    );

    // Scan divider: clkDiv toggles every DIV_COUNT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            clk_div_r <= 1'b0;
        end else if (tc_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            clk_div_r <= ~clk_div_r;
        end else begin
            cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            clk_div_r <= clk_div_r;
        end
    end

    // Handshake FSM with pending and shadow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            ready_r        <= 1'b1;
            pend_value_r   <= 8'h00;
            pend_dp_r      <= 2'b00;
            pend_blank_r   <= 1'b0;
            shadow_value_r <= 8'h00;
            shadow_dp_r    <= 2'b00;
            shadow_blank_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        pend_value_r <= value;
                        pend_dp_r    <= dp;
                        pend_blank_r <= blank_lz;
                        state_r      <= ST_PEND;
                        ready_r      <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (boundary_s) begin
                        shadow_value_r <= pend_value_r;
                        shadow_dp_r    <= pend_dp_r;
                        shadow_blank_r <= pend_blank_r;
                        state_r        <= ST_IDLE;
                        ready_r        <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Segment outputs only move at a frame boundary; frame marks that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led1_r  <= SEG_HEX_0;
            led2_r  <= SEG_HEX_0;
            frame_r <= 1'b0;
        end else begin
            frame_r <= boundary_s;
            if (boundary_s) begin
                led1_r <= seg1_s;
                led2_r <= seg2_s;
            end
        end
    end

    assign ready  = ready_r;
    assign clkDiv = clk_div_r;
    assign led1   = led1_r;
    assign led2   = led2_r;
    assign frame  = frame_r;

endmodule

// File: tb/tb_seg_feed.sv
// Bench for seg_feed at DIV_COUNT=4: vector table of loads with a scoreboard of
// expected displays, plus hand-written boundary, ignored-load and reset sequences.
module tb_seg_feed;

    localparam int DIV   = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic [1:0] dp = 2'b00;
    logic       blank_lz = 1'b0;
    logic       load = 1'b0;
    logic       ready;
    logic       clkDiv;
    logic [7:0] led1;
    logic [7:0] led2;
    logic       frame;

    seg_feed #(.DIV_COUNT(DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp       (dp),
        .blank_lz (blank_lz),
        .load     (load),
        .ready    (ready),
        .clkDiv   (clkDiv),
        .led1     (led1),
        .led2     (led2),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        logic [1:0] dp;
        logic       blank;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic [1:0] d, input logic b,
                           input logic [15:0] exp);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_load", ready, 1);
        value    = v;
        dp       = d;
        blank_lz = b;
        load     = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        load = 1'b0;
        check("ready_drop", ready, 0);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        @(negedge clk);
        while (!frame && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", frame, 1);
    endtask

    // Scoreboard monitor: every change of the displayed pair must match the next expected entry
    initial begin
        logic [15:0] last;
        last = 16'hC0C0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = {led1, led2};
            end else if ({led1, led2} !== last) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", {led1, led2}, last);
                end else begin
                    check("sb_leds", {led1, led2}, exp_q.pop_front());
                end
                check("update_on_frame", frame, 1);
                last = {led1, led2};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{8'h3A, 2'b00, 1'b0, 8'hB0, 8'h88};
        vecs[1] = '{8'h05, 2'b00, 1'b1, 8'hFF, 8'h92};
        vecs[2] = '{8'h80, 2'b10, 1'b0, 8'h00, 8'hC0};
        vecs[3] = '{8'h0C, 2'b01, 1'b1, 8'hFF, 8'h46};
        vecs[4] = '{8'hE7, 2'b11, 1'b0, 8'h06, 8'h78};
        vecs[5] = '{8'hB0, 2'b00, 1'b1, 8'h83, 8'hC0};
        vecs[6] = '{8'h00, 2'b10, 1'b1, 8'h7F, 8'hC0};

        // Reset values and divider cadence
        repeat (3) @(negedge clk);
        check("rst_led1", led1, 8'hC0);
        check("rst_led2", led2, 8'hC0);
        check("rst_ready", ready, 1);
        check("rst_clkdiv", clkDiv, 0);
        check("rst_frame", frame, 0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("clkdiv_cadence", clkDiv, (k / DIV) % 2);
            check("frame_cadence", frame, (k % (2 * DIV)) == 0);
        end

        // Table-driven loads, each checked at its commit frame
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].value, vecs[i].dp, vecs[i].blank, {vecs[i].e1, vecs[i].e2});
            wait_frame(n);
            check("vec_led1", led1, vecs[i].e1);
            check("vec_led2", led2, vecs[i].e2);
            check("vec_ready", ready, 1);
            check("vec_clkdiv", clkDiv, 0);
        end

        // Second load while pending is ignored
        do_load(8'h11, 2'b00, 1'b0, 16'hF9F9);
        value = 8'h22;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pend_ready", ready, 0);
        wait_frame(n);
        check("ign_led1", led1, 8'hF9);
        check("ign_led2", led2, 8'hF9);
        wait_frame(n);
        check("ign_hold", {led1, led2}, 16'hF9F9);
        check("ign_ready", ready, 1);

        // Load accepted on the boundary edge commits one frame later
        repeat (2 * DIV - 1) @(negedge clk);
        value = 8'h44;
        dp    = 2'b00;
        blank_lz = 1'b0;
        load  = 1'b1;
        exp_q.push_back(16'h9999);
        @(negedge clk);
        load = 1'b0;
        check("bnd_frame", frame, 1);
        check("bnd_ready", ready, 0);
        check("bnd_hold", {led1, led2}, 16'hF9F9);
        wait_frame(n);
        check("bnd_gap", n, 2 * DIV - 1);
        check("bnd_leds", {led1, led2}, 16'h9999);
        check("bnd_ready2", ready, 1);

        // Reset while a value is pending discards it
        do_load(8'hFF, 2'b00, 1'b0, 16'h8E8E);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_leds", {led1, led2}, 16'hC0C0);
        check("mid_rst_ready", ready, 1);
        rst = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        check("post_rst_leds", {led1, led2}, 16'hC0C0);
        check("post_rst_ready", ready, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
